lockin_demod: RTL
=================

// Module: lockin_demod
// PURPOSE
//   Lock-in demodulator downstream of sine_gen: multiplies the photodiode ADC
//   sample by the sine_gen reference and integrates the product over a
//   programmable window of samples. Emits one scaled error word per window
//   for the OPO lock PID loop.
// PARAMETERS
//   ACC_W      64  accumulator width in bits, two's complement
//   OUT_SHIFT  16  arithmetic right shift applied to the window sum before output
// PORTS
//   clk          in   1           250 MHz system clock
//   rst          in   1           asynchronous reset, active low
//   enable       in   1           1 = run windows; 0 = flush and idle
//   n_samples    in   32          window length in samples; 0 is treated as 1
//   adc_in       in   word_width  signed photodiode sample, one per clk
//   ref_in       in   word_width  signed reference, sine_gen sine_out
//   demod_out    out  word_width  signed scaled window sum
//   demod_valid  out  1           one-clk pulse when demod_out updates
//   busy         out  1           1 while in RUN or while the pipeline drains
// BEHAVIOUR
//   Reset values: demod_out=0, demod_valid=0, busy=0. Reset clears all pipeline
//     registers, tags, the counter, the accumulator and the FSM.
//   FSM states are IDLE and RUN.
//     IDLE->RUN when enable=1. RUN->IDLE when enable=0.
//   Window length: n_samples is latched at the first sample of each window.
//     A mid-window change to n_samples takes effect at the next window.
//   Pipeline S0/S1/S2, each stage one register:
//     S0 captures adc_in, ref_in and the first/last tags.
//     S1 computes the signed 2*word_width-bit product and sign-extends it to ACC_W.
//     S2 accumulates. A first-tagged product loads acc. Other products add into acc.
//     S2 with a last-tagged product also computes sum=acc+product (product alone
//       if it is also first) and drives demod_valid=1 for one cycle.
//   In RUN every clk captures one sample. The sample counter runs 0..N-1.
//     Count 0 carries the first tag; count N-1 carries the last tag.
//     With N=1, each sample carries both tags.
//   Windows run back to back with no gap cycle.
//   Latency: demod_valid is asserted 3 clks after the capture of the last sample.
//   Scaling: scaled = sum >>> OUT_SHIFT (arithmetic shift, floor toward -inf).
//   Accumulator overflow wraps modulo 2^ACC_W.
//   enable falling mid-window: the partial window is discarded. No demod_valid
//     is produced for it, and samples already in flight carry no last tag.
//     The next enable rise starts a fresh window at count 0.
//   busy=1 in RUN and while S0/S1 still hold tagged data.
//   demod_out holds its value between pulses.
// CONFIGURATION
//   LOCKIN_SATURATE_EN defined: scaled is clamped to
//     [-2^(word_width-1), 2^(word_width-1)-1] before it drives demod_out.
//   LOCKIN_SATURATE_EN undefined: demod_out = scaled[word_width-1:0], plain
//     truncation with wrap.
// STRUCTURE
//   opo_package holds word_width and a new constant lockin_acc_width=64.
//     ACC_W defaults to lockin_acc_width.
//   opo_package also holds typedef lockin_state_t {LI_IDLE, LI_RUN}.
//   One sub-module, lockin_scale: shift plus optional saturation, combinational,
//     instantiated once at the output.
// TESTING (values for word_width=16, OUT_SHIFT=16)
//   1. adc=1000, ref=2000 constant, n=4, enable=1:
//      demod_out=122 every 4 clks; first pulse 3 clks after the 4th capture.
//   2. adc=-1000, ref=2000, n=4: demod_out=-123, checking the floor shift.
//   3. Test 1 with OUT_SHIFT=0 and LOCKIN_SATURATE_EN defined: demod_out=32767.
//      Same test with LOCKIN_SATURATE_EN undefined: demod_out=4608.
//   4. n=0 and n=1, adc=ref=256: a pulse every clk with demod_out=1, no gaps.
//   5. n=8, drop enable after 5 samples: no pulse for the partial window.
//      Re-enable: the next pulse arrives exactly 8 samples + 3 clks later.
//   6. Change n from 4 to 2 mid-window: current window closes at 4, next at 2.
//      Also: rst low mid-window returns all outputs to 0 immediately.

Source files
------------

// File: rtl/opo_package.sv
// Shared OPO-lock constants and types.
// Used by the lock-in demodulator (lockin_demod, lockin_scale).
package opo_package;

    localparam int unsigned word_width       = 16;
    localparam int unsigned lockin_acc_width = 64;

    typedef enum logic [0:0] {LI_IDLE, LI_RUN} lockin_state_t;

endpackage

// File: rtl/lockin_scale.sv
// Output scaler for the lock-in window sum: arithmetic right shift, then either
// clamp (LOCKIN_SATURATE_EN defined) or truncate with wrap (default).
module lockin_scale
    import opo_package::*;
#(
    parameter int unsigned ACC_W     = lockin_acc_width,
    parameter int unsigned OUT_SHIFT = 16
) (
    input  logic signed [ACC_W-1:0]      sum,
    output logic signed [word_width-1:0] scaled
);

`ifdef LOCKIN_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SatMax =
        {{(ACC_W-word_width+1){1'b0}}, {(word_width-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin =
        {{(ACC_W-word_width+1){1'b1}}, {(word_width-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = sum >>> OUT_SHIFT;
        if (shifted > SatMax) begin
            scaled = SatMax[word_width-1:0];
        end else if (shifted < SatMin) begin
            scaled = SatMin[word_width-1:0];
        end else begin
            scaled = shifted[word_width-1:0];
        end
    end
`else
    assign scaled = word_width'(sum >>> OUT_SHIFT);
`endif

endmodule

// File: rtl/lockin_demod.sv
// Lock-in demodulator: multiplies ADC by reference, integrates over n_samples,
// emits one scaled word per window. Optional clamp via LOCKIN_SATURATE_EN.
module lockin_demod
    import opo_package::*;
#(
    parameter int unsigned ACC_W     = lockin_acc_width,
    parameter int unsigned OUT_SHIFT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [31:0]                  n_samples,
    input  logic signed [word_width-1:0] adc_in,
    input  logic signed [word_width-1:0] ref_in,
    output logic signed [word_width-1:0] demod_out,
    output logic                         demod_valid,
    output logic                         busy
);

    lockin_state_t state_q;
    logic [31:0]   cnt_q, len_q, eff_len;
    logic          run, tag_first, tag_last;

    logic                         s0_vld_q, s0_first_q, s0_last_q;
    logic signed [word_width-1:0] s0_adc_q, s0_ref_q;
    logic signed [2*word_width-1:0] prod;

    logic                    s1_vld_q, s1_first_q, s1_last_q;
    logic signed [ACC_W-1:0] s1_prod_q;

    logic signed [ACC_W-1:0] acc_q, acc_d, sum_q;
    logic                    s2_last_q;

    logic signed [word_width-1:0] scaled, demod_out_q;
    logic                         demod_valid_q;

    // Window length is only sampled on the first sample; later samples use the latch.
    always_comb begin
        run       = (state_q == LI_RUN) && enable;
        tag_first = (cnt_q == 32'd0);
        eff_len   = tag_first ? ((n_samples == 32'd0) ? 32'd1 : n_samples) : len_q;
        tag_last  = (cnt_q == eff_len - 32'd1);
        prod      = s0_adc_q * s0_ref_q;
        acc_d     = s1_first_q ? s1_prod_q : acc_q + s1_prod_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LI_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            unique case (state_q)
                LI_IDLE: if (enable)  state_q <= LI_RUN;
                LI_RUN:  if (!enable) state_q <= LI_IDLE;
                default:              state_q <= LI_IDLE;
            endcase
            if (run) begin
                cnt_q <= tag_last ? 32'd0 : cnt_q + 32'd1;
                if (tag_first) len_q <= eff_len;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Stages drain after enable falls; the partial window simply never sees a last tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_vld_q      <= 1'b0;
            s0_first_q    <= 1'b0;
            s0_last_q     <= 1'b0;
            s0_adc_q      <= '0;
            s0_ref_q      <= '0;
            s1_vld_q      <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_prod_q     <= '0;
            acc_q         <= '0;
            sum_q         <= '0;
            s2_last_q     <= 1'b0;
            demod_out_q   <= '0;
            demod_valid_q <= 1'b0;
        end else begin
            s0_vld_q   <= run;
            s0_first_q <= run && tag_first;
            s0_last_q  <= run && tag_last;
            s0_adc_q   <= adc_in;
            s0_ref_q   <= ref_in;

            s1_vld_q   <= s0_vld_q;
            s1_first_q <= s0_first_q;
            s1_last_q  <= s0_last_q;
            s1_prod_q  <= {{(ACC_W-2*word_width){prod[2*word_width-1]}}, prod};

            if (s1_vld_q) acc_q <= acc_d;
            s2_last_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q && s1_last_q) sum_q <= acc_d;

            demod_valid_q <= s2_last_q;
            if (s2_last_q) demod_out_q <= scaled;
        end
    end

    lockin_scale #(
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_scale (
        .sum    (sum_q),
        .scaled (scaled)
    );

    assign demod_out   = demod_out_q;
    assign demod_valid = demod_valid_q;
    assign busy        = (state_q == LI_RUN) || s0_vld_q || s1_vld_q;

endmodule
